// File: rtl/parity_tx_if.sv
// Handshake and serial-output bundle for parity_tx: parallel word in, framed bit stream out.
// The transmitter takes the slave side; whoever feeds words and watches the stream takes master.
interface parity_tx_if #(
  parameter int WIDTH = 8
) ();
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             z;
  logic             z_valid;
  logic             done;

  modport master (
    output din, din_valid,
    input  din_ready, z, z_valid, done
  );

  modport slave (
    input  din, din_valid,
    output din_ready, z, z_valid, done
  );
endinterface

// File: rtl/parity_tx.sv
// Serialises a WIDTH-bit word LSB first followed by an even/odd parity bit; first bit one cycle after accept.
// din_ready only in IDLE and PARITY, so frames chain gaplessly; PARITY_TX_START_BIT_EN adds a leading 0 start bit.
module parity_tx #(
  parameter int WIDTH = 8,
  parameter bit ODD   = 1'b0
) (
  input  logic     clk,
  input  logic     rst_n,
  parity_tx_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

`ifdef PARITY_TX_START_BIT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2, START = 2'd3} state_e;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2} state_e;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             par_q, par_d;
  logic             accept;
  logic             din_ready;
  logic             z;
  logic             z_valid;
  logic             done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    par_d     = par_q;
    din_ready = 1'b0;
    z         = 1'b0;
    z_valid   = 1'b0;
    done      = 1'b0;

    case (state_q)
      IDLE: begin
        din_ready = 1'b1;
      end
`ifdef PARITY_TX_START_BIT_EN
      START: begin
        z_valid = 1'b1;
        state_d = DATA;
      end
`endif
      DATA: begin
        z       = sr_q[0];
        z_valid = 1'b1;
        sr_d    = sr_q >> 1;
        par_d   = par_q ^ sr_q[0];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          state_d = PARITY;
        end
      end
      PARITY: begin
        z         = par_q ^ ODD;
        z_valid   = 1'b1;
        done      = 1'b1;
        din_ready = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A new word overrides whatever the current state would do next, including leaving PARITY.
    accept = bus.din_valid & din_ready;
    if (accept) begin
      sr_d  = bus.din;
      cnt_d = '0;
      par_d = 1'b0;
`ifdef PARITY_TX_START_BIT_EN
      state_d = START;
`else
      state_d = DATA;
`endif
    end
  end

  assign bus.din_ready = din_ready;
  assign bus.z         = z;
  assign bus.z_valid   = z_valid;
  assign bus.done      = done;

endmodule

// File: tb/tb_parity_tx.sv
// Bench for parity_tx: three instances (8-bit even, 8-bit odd, 1-bit even), expected {z,done} per cycle
// queued from a bit-level model when a word is driven and popped as each frame bit appears.
module tb_parity_tx;

`ifdef PARITY_TX_START_BIT_EN
  localparam int SB = 1;
`else
  localparam int SB = 0;
`endif
  localparam int FL8 = 8 + 1 + SB;
  localparam int FL1 = 1 + 1 + SB;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [1:0] exp_q[$];

  always #5 clk = ~clk;

  parity_tx_if #(.WIDTH(8)) a_if ();
  parity_tx_if #(.WIDTH(8)) o_if ();
  parity_tx_if #(.WIDTH(1)) w_if ();

  parity_tx #(.WIDTH(8), .ODD(1'b0)) u_even (.clk(clk), .rst_n(rst_n), .bus(a_if.slave));
  parity_tx #(.WIDTH(8), .ODD(1'b1)) u_odd  (.clk(clk), .rst_n(rst_n), .bus(o_if.slave));
  parity_tx #(.WIDTH(1), .ODD(1'b0)) u_w1   (.clk(clk), .rst_n(rst_n), .bus(w_if.slave));

  function automatic void push_frame(input logic [7:0] d, input int w, input bit odd);
    logic p;
    p = odd;
    if (SB != 0) exp_q.push_back(2'b00);
    for (int i = 0; i < w; i++) begin
      exp_q.push_back({d[i], 1'b0});
      p = p ^ d[i];
    end
    exp_q.push_back({p, 1'b1});
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    a_if.din = '0; a_if.din_valid = 1'b0;
    o_if.din = '0; o_if.din_valid = 1'b0;
    w_if.din = '0; w_if.din_valid = 1'b0;
    #12;
    n_checks++; if (a_if.z !== 1'b0) begin n_fail++; $display("FAIL reset_z: got %b expected 0", a_if.z); end
    n_checks++; if (a_if.z_valid !== 1'b0) begin n_fail++; $display("FAIL reset_z_valid: got %b expected 0", a_if.z_valid); end
    n_checks++; if (a_if.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", a_if.done); end
    n_checks++; if (a_if.din_ready !== 1'b1) begin n_fail++; $display("FAIL reset_din_ready: got %b expected 1", a_if.din_ready); end
    n_checks++; if (w_if.z_valid !== 1'b0) begin n_fail++; $display("FAIL reset_w1_z_valid: got %b expected 0", w_if.z_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (a_if.z_valid !== 1'b0) begin n_fail++; $display("FAIL idle_z_valid: got %b expected 0", a_if.z_valid); end
  endtask

  task automatic test_single_frame();
    logic [1:0] e;
    exp_q.delete();
    push_frame(8'hA5, 8, 1'b0);
    @(posedge clk); #1;
    a_if.din = 8'hA5; a_if.din_valid = 1'b1;
    @(negedge clk);
    n_checks++; if (a_if.din_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready_idle: got %b expected 1", a_if.din_ready); end
    @(posedge clk); #1;
    a_if.din_valid = 1'b0; a_if.din = 8'h5A;
    for (int i = 0; i < FL8; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++; if (a_if.z_valid !== 1'b1) begin n_fail++; $display("FAIL single_z_valid[%0d]: got %b expected 1", i, a_if.z_valid); end
      n_checks++; if (a_if.z !== e[1]) begin n_fail++; $display("FAIL single_z[%0d]: got %b expected %b", i, a_if.z, e[1]); end
      n_checks++; if (a_if.done !== e[0]) begin n_fail++; $display("FAIL single_done[%0d]: got %b expected %b", i, a_if.done, e[0]); end
      n_checks++; if (a_if.din_ready !== e[0]) begin n_fail++; $display("FAIL single_ready[%0d]: got %b expected %b", i, a_if.din_ready, e[0]); end
    end
    @(negedge clk);
    n_checks++; if (a_if.z_valid !== 1'b0) begin n_fail++; $display("FAIL single_tail_z_valid: got %b expected 0", a_if.z_valid); end
    n_checks++; if (a_if.done !== 1'b0) begin n_fail++; $display("FAIL single_tail_done: got %b expected 0", a_if.done); end
  endtask

  task automatic test_odd_parity();
    logic [1:0] e;
    logic       par_seen;
    par_seen = 1'bx;
    exp_q.delete();
    push_frame(8'hA5, 8, 1'b1);
    @(posedge clk); #1;
    o_if.din = 8'hA5; o_if.din_valid = 1'b1;
    @(posedge clk); #1;
    o_if.din_valid = 1'b0; o_if.din = 8'h00;
    for (int i = 0; i < FL8; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++; if (o_if.z_valid !== 1'b1) begin n_fail++; $display("FAIL odd_z_valid[%0d]: got %b expected 1", i, o_if.z_valid); end
      n_checks++; if (o_if.z !== e[1]) begin n_fail++; $display("FAIL odd_z[%0d]: got %b expected %b", i, o_if.z, e[1]); end
      n_checks++; if (o_if.done !== e[0]) begin n_fail++; $display("FAIL odd_done[%0d]: got %b expected %b", i, o_if.done, e[0]); end
      if (o_if.done === 1'b1) par_seen = o_if.z;
    end
    n_checks++; if (par_seen !== 1'b1) begin n_fail++; $display("FAIL odd_parity_a5: got %b expected 1", par_seen); end
    @(negedge clk);
    n_checks++; if (o_if.z_valid !== 1'b0) begin n_fail++; $display("FAIL odd_tail_z_valid: got %b expected 0", o_if.z_valid); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] e;
    logic       xor_acc;
    logic       par_seen;
    xor_acc  = 1'b0;
    par_seen = 1'bx;
    exp_q.delete();
    push_frame(8'hA5, 8, 1'b0);
    push_frame(8'h07, 8, 1'b0);
    @(posedge clk); #1;
    a_if.din = 8'hA5; a_if.din_valid = 1'b1;
    @(posedge clk); #1;
    a_if.din = 8'h07;
    for (int i = 0; i < 2 * FL8; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      xor_acc = xor_acc ^ a_if.z;
      n_checks++; if (a_if.z_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_z_valid[%0d]: got %b expected 1", i, a_if.z_valid); end
      n_checks++; if (a_if.z !== e[1]) begin n_fail++; $display("FAIL b2b_z[%0d]: got %b expected %b", i, a_if.z, e[1]); end
      n_checks++; if (a_if.done !== e[0]) begin n_fail++; $display("FAIL b2b_done[%0d]: got %b expected %b", i, a_if.done, e[0]); end
      n_checks++; if (a_if.din_ready !== e[0]) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %b expected %b", i, a_if.din_ready, e[0]); end
      if (e[0] === 1'b1) begin
        n_checks++; if (xor_acc !== 1'b0) begin n_fail++; $display("FAIL b2b_stream_xor[%0d]: got %b expected 0", i, xor_acc); end
        xor_acc  = 1'b0;
        par_seen = a_if.z;
      end
      if (i == FL8 - 1) begin
        @(posedge clk); #1;
        a_if.din_valid = 1'b0; a_if.din = 8'hEE;
      end
    end
    n_checks++; if (par_seen !== 1'b1) begin n_fail++; $display("FAIL even_parity_07: got %b expected 1", par_seen); end
    @(negedge clk);
    n_checks++; if (a_if.z_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_tail_z_valid: got %b expected 0", a_if.z_valid); end
  endtask

  task automatic test_reset_mid_frame();
    logic [1:0] e;
    logic       xor_acc;
    xor_acc = 1'b0;
    exp_q.delete();
    push_frame(8'hA5, 8, 1'b0);
    @(posedge clk); #1;
    a_if.din = 8'hA5; a_if.din_valid = 1'b1;
    @(posedge clk); #1;
    a_if.din_valid = 1'b0;
    for (int i = 0; i < SB + 3; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++; if (a_if.z !== e[1]) begin n_fail++; $display("FAIL abort_pre_z[%0d]: got %b expected %b", i, a_if.z, e[1]); end
    end
    rst_n = 1'b0;
    #1;
    n_checks++; if (a_if.z_valid !== 1'b0) begin n_fail++; $display("FAIL abort_z_valid: got %b expected 0", a_if.z_valid); end
    n_checks++; if (a_if.done !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %b expected 0", a_if.done); end
    n_checks++; if (a_if.z !== 1'b0) begin n_fail++; $display("FAIL abort_z: got %b expected 0", a_if.z); end
    a_if.din = 8'hFF; a_if.din_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++; if (a_if.z_valid !== 1'b0) begin n_fail++; $display("FAIL in_reset_z_valid[%0d]: got %b expected 0", i, a_if.z_valid); end
    end
    rst_n = 1'b1;
    #1;
    n_checks++; if (a_if.din_ready !== 1'b1) begin n_fail++; $display("FAIL release_ready: got %b expected 1", a_if.din_ready); end
    n_checks++; if (a_if.z_valid !== 1'b0) begin n_fail++; $display("FAIL release_z_valid: got %b expected 0", a_if.z_valid); end
    exp_q.delete();
    push_frame(8'hFF, 8, 1'b0);
    @(posedge clk); #1;
    a_if.din_valid = 1'b0; a_if.din = 8'h00;
    for (int i = 0; i < FL8; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      xor_acc = xor_acc ^ a_if.z;
      n_checks++; if (a_if.z !== e[1]) begin n_fail++; $display("FAIL ff_z[%0d]: got %b expected %b", i, a_if.z, e[1]); end
      n_checks++; if (a_if.done !== e[0]) begin n_fail++; $display("FAIL ff_done[%0d]: got %b expected %b", i, a_if.done, e[0]); end
    end
    n_checks++; if (xor_acc !== 1'b0) begin n_fail++; $display("FAIL ff_stream_xor: got %b expected 0", xor_acc); end
    @(negedge clk);
    n_checks++; if (a_if.z_valid !== 1'b0) begin n_fail++; $display("FAIL ff_tail_z_valid: got %b expected 0", a_if.z_valid); end
  endtask

  task automatic test_width1();
    logic [1:0] e;
    for (int k = 0; k < 2; k++) begin
      logic bitv;
      bitv = (k == 0) ? 1'b1 : 1'b0;
      exp_q.delete();
      push_frame({7'b0, bitv}, 1, 1'b0);
      @(posedge clk); #1;
      w_if.din = bitv; w_if.din_valid = 1'b1;
      @(posedge clk); #1;
      w_if.din_valid = 1'b0; w_if.din = ~bitv;
      for (int i = 0; i < FL1; i++) begin
        @(negedge clk);
        e = exp_q.pop_front();
        n_checks++; if (w_if.z_valid !== 1'b1) begin n_fail++; $display("FAIL w1_z_valid[%0d.%0d]: got %b expected 1", k, i, w_if.z_valid); end
        n_checks++; if (w_if.z !== e[1]) begin n_fail++; $display("FAIL w1_z[%0d.%0d]: got %b expected %b", k, i, w_if.z, e[1]); end
        n_checks++; if (w_if.done !== e[0]) begin n_fail++; $display("FAIL w1_done[%0d.%0d]: got %b expected %b", k, i, w_if.done, e[0]); end
      end
      @(negedge clk);
      n_checks++; if (w_if.z_valid !== 1'b0) begin n_fail++; $display("FAIL w1_tail_z_valid[%0d]: got %b expected 0", k, w_if.z_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_odd_parity();
    test_back_to_back();
    test_reset_mid_frame();
    test_width1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
